// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, parity modes and per-word status flags.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef struct packed {
    logic perr;
    logic ferr;
    logic brk;
  } rx_flags_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx line synchroniser plus optional 2-of-3 majority filter on s_tick samples.
// Macro UART_RX_MAJORITY_EN selects the majority filter; otherwise the bit is rx_s itself.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rx_i,
  input  logic s_tick_i,
  output logic rx_s_o,
  output logic sample_c_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx_i};
  end

  assign rx_s_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds rx_s from the previous tick, hist_q[1] from the one before
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      hist_q <= 2'b11;
    else if (s_tick_i) hist_q <= {hist_q[0], sync_q[1]};
  end

  assign sample_c_o = maj3(sync_q[1], hist_q[0], hist_q[1]);
`else
  logic unused_tick_c;
  assign unused_tick_c = s_tick_i;
  assign sample_c_o    = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampled UART receiver with false-start rejection, error reporting and a 1-word output holding register.
// Optional build macro: UART_RX_MAJORITY_EN (majority-vote sampling, decisions one s_tick later).
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned OVS       = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun_err,
  input  logic            err_clr
);

  localparam int unsigned SW = $clog2(OVS);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic rx_s, smp_c;

  uart_rx_sampler u_smp (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_i      (rx),
    .s_tick_i  (s_tick),
    .rx_s_o    (rx_s),
    .sample_c_o(smp_c)
  );

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            pend_q, pend_d;
  logic            wrap_c, decide_c, done_c, fe_c;

  logic [DBIT-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  rx_flags_t       flags_q, flags_d;
  logic            ovr_q, ovr_d;

  // Counter wraps at the sample position; with majority sampling the decision lands one tick later
  always_comb begin
    state_d  = state_q;
    s_cnt_d  = s_cnt_q;
    n_cnt_d  = n_cnt_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    pend_d   = pend_q;
    done_c   = 1'b0;
    fe_c     = 1'b0;
    wrap_c   = s_tick && (s_cnt_q == ((state_q == START) ? S_MID : S_LAST));
    decide_c = MAJ ? (s_tick && pend_q) : wrap_c;

    case (state_q)
      IDLE: begin
        s_cnt_d = '0;
        n_cnt_d = '0;
        pend_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (!rx_s) state_d = START;
      end
      BRK_WAIT: begin
        s_cnt_d = '0;
        pend_d  = 1'b0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        if (s_tick) begin
          s_cnt_d = wrap_c ? '0 : s_cnt_q + SW'(1);
          pend_d  = wrap_c;
        end
        if (decide_c) begin
          case (state_q)
            START: begin
              if (smp_c) begin
                state_d = IDLE;
                s_cnt_d = '0;
              end else begin
                state_d = DATA;
                n_cnt_d = '0;
              end
            end
            DATA: begin
              shreg_d = {smp_c, shreg_q[DBIT-1:1]};
              if (n_cnt_q == N_LAST) begin
                n_cnt_d = '0;
                state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
              end else begin
                n_cnt_d = n_cnt_q + NW'(1);
              end
            end
            uart_pkg::PARITY: begin
              perr_d  = (^shreg_q) ^ smp_c ^ (PARITY == PAR_ODD);
              state_d = STOP;
            end
            STOP: begin
              fe_c   = ferr_q | ~smp_c;
              ferr_d = fe_c;
              if (n_cnt_q == N_STOP) begin
                done_c  = 1'b1;
                state_d = fe_c ? BRK_WAIT : IDLE;
              end else begin
                n_cnt_d = n_cnt_q + NW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Holding register: a completion loads only if the slot is empty or being drained this cycle
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    flags_d = flags_q;
    ovr_d   = ovr_q;
    if (valid_q && dout_ready) valid_d = 1'b0;
    if (err_clr) ovr_d = 1'b0;
    if (done_c) begin
      if (!valid_q || dout_ready) begin
        dout_d       = shreg_q;
        valid_d      = 1'b1;
        flags_d.perr = perr_q;
        flags_d.ferr = fe_c;
        flags_d.brk  = fe_c && (shreg_q == '0);
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign parity_err  = flags_q.perr;
  assign frame_err   = flags_q.ferr;
  assign break_det   = flags_q.brk;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: three instances (even parity, odd parity, 9-bit/2-stop) with scoreboards.
module tb_uart_rx_ext;

  localparam int BIT = 64;  // 16 s_ticks x 4 clk

  logic clk = 1'b0;
  logic reset_n, s_tick, ready, err_clr, rx_ab, rx_c;
  logic [7:0] dout_a, dout_b;
  logic [8:0] dout_c;
  logic valid_a, pe_a, fe_a, bk_a, ov_a;
  logic valid_b, pe_b, fe_b, bk_b, ov_b;
  logic valid_c, pe_c, fe_c, bk_c, ov_c;

  int total = 0;
  int bad   = 0;
  int vcnt_a = 0;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       pe;   // expected parity_err for even parity
    logic       fe;
    logic       bk;
  } vec_t;

  exp_t q_a[$], q_b[$], q_c[$];
  vec_t vt[8];

  always #5 clk = ~clk;

  uart_rx_ext #(.DBIT(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_ab), .s_tick(s_tick),
    .dout(dout_a), .dout_valid(valid_a), .dout_ready(ready),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a),
    .overrun_err(ov_a), .err_clr(err_clr));

  uart_rx_ext #(.DBIT(8), .OVS(16), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_ab), .s_tick(s_tick),
    .dout(dout_b), .dout_valid(valid_b), .dout_ready(ready),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b),
    .overrun_err(ov_b), .err_clr(err_clr));

  uart_rx_ext #(.DBIT(9), .OVS(16), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset_n(reset_n), .rx(rx_c), .s_tick(s_tick),
    .dout(dout_c), .dout_valid(valid_c), .dout_ready(ready),
    .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c),
    .overrun_err(ov_c), .err_clr(err_clr));

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_word(input string nm, input exp_t e, input logic [8:0] d,
                            input logic pe, input logic fe, input logic bk);
    chk({nm, "_dout"}, d, e.d);
    chk({nm, "_perr"}, 9'(pe), 9'(e.pe));
    chk({nm, "_ferr"}, 9'(fe), 9'(e.fe));
    chk({nm, "_brk"},  9'(bk), 9'(e.bk));
  endtask

  task automatic unexpected(input string nm, input logic [8:0] d);
    total++;
    bad++;
    $display("FAIL %s_unexpected_word got=%h exp=none at %0t", nm, d, $time);
  endtask

  // Scoreboard pop on every accepted word
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (valid_a) vcnt_a++;
      if (valid_a && ready) begin
        if (q_a.size() == 0) unexpected("a", 9'(dout_a));
        else check_word("a", q_a.pop_front(), 9'(dout_a), pe_a, fe_a, bk_a);
      end
      if (valid_b && ready) begin
        if (q_b.size() == 0) unexpected("b", 9'(dout_b));
        else check_word("b", q_b.pop_front(), 9'(dout_b), pe_b, fe_b, bk_b);
      end
      if (valid_c && ready) begin
        if (q_c.size() == 0) unexpected("c", dout_c);
        else check_word("c", q_c.pop_front(), dout_c, pe_c, fe_c, bk_c);
      end
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic push_ab(input logic [7:0] d, input logic pe_even, input logic fe, input logic bk);
    q_a.push_back('{9'(d), pe_even, fe, bk});
    q_b.push_back('{9'(d), ~pe_even, fe, bk});
  endtask

  task automatic send_bit(input int line, input logic v);
    if (line == 0) rx_ab = v;
    else           rx_c  = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // glitch >= 0 puts a 1-clk inverted pulse in the middle of that data bit
  task automatic send_frame(input int line, input logic [8:0] d, input int nb, input bit has_par,
                            input logic par, input logic st1, input logic st2, input int nst,
                            input int glitch);
    send_bit(line, 1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch) begin
        rx_ab = d[i];
        repeat (BIT / 2) @(posedge clk);
        #1 rx_ab = ~d[i];
        @(posedge clk);
        #1 rx_ab = d[i];
        repeat (BIT / 2 - 1) @(posedge clk);
        #1;
      end else begin
        send_bit(line, d[i]);
      end
    end
    if (has_par) send_bit(line, par);
    send_bit(line, st1);
    if (nst > 1) send_bit(line, st2);
    send_bit(line, 1'b1);
    send_bit(line, 1'b1);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_drain got=pending exp=empty", nm);
    end
  endtask

  initial begin
    int v0;
    vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; rx_ab = 1'b1; rx_c = 1'b1; ready = 1'b1; err_clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", 9'(dout_a), 9'h000);
    chk("rst_valid", 9'(valid_a), 9'h0);
    chk("rst_ovr", 9'(ov_a), 9'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    send_bit(0, 1'b1);

    // Table: clean, parity, framing and break-shaped words on the parity line
    for (int i = 0; i < 8; i++) begin
      v0 = vcnt_a;
      push_ab(vt[i].d, vt[i].pe, vt[i].fe, vt[i].bk);
      send_frame(0, 9'(vt[i].d), 8, 1'b1, vt[i].par, vt[i].stop, 1'b1, 1, -1);
      wait_drain("vec");
      if (i == 0) chk("valid_pulse_len", 9'(vcnt_a - v0), 9'd1);
    end

    // False start: low for 6 s_ticks only
    v0 = vcnt_a;
    rx_ab = 1'b0;
    repeat (24) @(posedge clk);
    #1 rx_ab = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1 chk("glitch_no_word", 9'(vcnt_a - v0), 9'd0);
    push_ab(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    wait_drain("after_glitch");

    // Overrun: consumer stalled across two frames
    ready = 1'b0;
    push_ab(8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h012, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    send_frame(0, 9'h034, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, -1);
    chk("ovr_hold_dout", 9'(dout_a), 9'h012);
    chk("ovr_hold_valid", 9'(valid_a), 9'h1);
    chk("ovr_set_a", 9'(ov_a), 9'h1);
    chk("ovr_set_b", 9'(ov_b), 9'h1);
    ready = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    wait_drain("ovr");
    repeat (2) @(posedge clk); #1;
    chk("ovr_valid_clear", 9'(valid_a), 9'h0);
    chk("ovr_clear", 9'(ov_a), 9'h0);

    // Line break: 40 bit times low yields exactly one word
    push_ab(8'h00, 1'b0, 1'b1, 1'b1);
    rx_ab = 1'b0;
    repeat (40 * BIT) @(posedge clk);
    #1 rx_ab = 1'b1;
    send_bit(0, 1'b1);
    wait_drain("break");
    push_ab(8'h96, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h096, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    wait_drain("after_break");

    // Reset mid-DATA with a held word and overrun pending
    ready = 1'b0;
    send_frame(0, 9'h077, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    send_frame(0, 9'h066, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    chk("pre_rst_ovr", 9'(ov_a), 9'h1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_dout", 9'(dout_a), 9'h000);
    chk("mid_rst_valid", 9'(valid_a), 9'h0);
    chk("mid_rst_flags", 9'({pe_a, fe_a, bk_a}), 9'h0);
    chk("mid_rst_ovr", 9'(ov_a), 9'h0);
    @(posedge clk); #1 rx_ab = 1'b1; ready = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    push_ab(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1);
    wait_drain("post_rst");

    // 9-bit, two stop bits, no parity
    q_c.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    send_frame(1, 9'h0A5, 9, 1'b0, 1'b0, 1'b1, 1'b1, 2, -1);
    wait_drain("c_clean");
    q_c.push_back('{9'h1FF, 1'b0, 1'b1, 1'b0});
    send_frame(1, 9'h1FF, 9, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
    wait_drain("c_stop2");
    q_c.push_back('{9'h000, 1'b0, 1'b1, 1'b1});
    send_frame(1, 9'h000, 9, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
    wait_drain("c_stop1");

`ifdef UART_RX_MAJORITY_EN
    push_ab(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0);
    wait_drain("maj_glitch0");
    push_ab(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 3);
    wait_drain("maj_glitch3");
`endif

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
